axi_rd_ctrl: RTL

Parametrised AXI4 read-channel slave controller. Accepts read requests into a small outstanding-request queue, then streams each burst's beats from a show-ahead output FIFO onto the R channel through a registered output stage at full throughput. Adds configurable widths, multiple outstanding requests, SLVERR responses for illegal bursts, and status outputs. Sits between the AXI interconnect slave port and the read-data FIFO.

---
 rtl/axi_rd_pkg.sv | 29 ++
 rtl/ar_queue.sv | 46 ++++
 rtl/axi_rd_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/axi_rd_pkg.sv
// Shared constants and helpers for the AXI4 read-channel slave controller.
package axi_rd_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] ST_IDLE   = 3'b001;
  localparam logic [2:0] ST_STREAM = 3'b010;
  localparam logic [2:0] ST_ERR    = 3'b100;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    STREAM = ST_STREAM,
    ERR    = ST_ERR
  } state_e;

  // A burst is rejected when its type is reserved or its beat is wider than the bus.
  function automatic logic burst_illegal(input logic [1:0] burst,
                                         input logic [2:0] size,
                                         input logic [2:0] max_size);
    return (burst == BURST_RSVD) || (size > max_size);
  endfunction

endpackage

// File: rtl/ar_queue.sv
// Small show-ahead FIFO holding accepted read requests until the engine starts them.
module ar_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0]   wr_ptr_reg;
  logic [PTR_W:0]   rd_ptr_reg;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                 (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
  assign head  = mem[rd_ptr_reg[PTR_W-1:0]];

  // Storage write; contents need no reset because the pointers qualify them.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr_reg[PTR_W-1:0]] <= push_data;
    end
  end

  // Pointer update; push and pop may coincide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push && !full) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop && !empty) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/axi_rd_ctrl.sv
// AXI4 read-channel slave: queues AR requests and streams R beats from the data FIFO.
module axi_rd_ctrl
  import axi_rd_pkg::*;
#(
  parameter int ID_W     = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int AR_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ID_W-1:0]   axs_s0_arid,
  input  logic [ADDR_W-1:0] axs_s0_araddr,
  input  logic [7:0]        axs_s0_arlen,
  input  logic [2:0]        axs_s0_arsize,
  input  logic [1:0]        axs_s0_arburst,
  input  logic              axs_s0_arvalid,
  output logic              axs_s0_arready,
  output logic [ID_W-1:0]   axs_s0_rid,
  output logic [DATA_W-1:0] axs_s0_rdata,
  output logic [1:0]        axs_s0_rresp,
  output logic              axs_s0_rlast,
  output logic              axs_s0_rvalid,
  input  logic              axs_s0_rready,
  input  logic              out_fifo_empty,
  input  logic [DATA_W-1:0] out_fifo_data,
  output logic              out_fifo_pop,
  output logic              busy,
  output logic [15:0]       slverr_count
);

  localparam int         Q_W      = ID_W + 13;
  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W / 8));

  logic             q_push;
  logic             q_pop;
  logic             q_full;
  logic             q_empty;
  logic [Q_W-1:0]   q_head;
  logic [ID_W-1:0]  head_id;
  logic [7:0]       head_len;
  logic [2:0]       head_size;
  logic [1:0]       head_burst;

  state_e           state_reg, state_next;
  logic [7:0]       beats_left_reg, beats_left_next;
  logic [ID_W-1:0]  cur_id_reg, cur_id_next;
  logic             err_entry;
  logic             issue;
  logic             slot_free;

  logic             rvalid_reg;
  logic             rlast_reg;
  logic [ID_W-1:0]  rid_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic [1:0]       rresp_reg;
  logic [15:0]      slverr_count_reg;

  // The address is accepted on the bus but never selects data.
  logic unused_araddr;
  assign unused_araddr = ^axs_s0_araddr;

  assign axs_s0_arready = !reset && !q_full;
  assign q_push         = axs_s0_arvalid && axs_s0_arready;
  assign slot_free      = !rvalid_reg || axs_s0_rready;
  assign {head_id, head_len, head_size, head_burst} = q_head;

  ar_queue #(
    .DEPTH (AR_DEPTH),
    .WIDTH (Q_W)
  ) u_ar_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .push_data ({axs_s0_arid, axs_s0_arlen, axs_s0_arsize, axs_s0_arburst}),
    .pop       (q_pop),
    .full      (q_full),
    .empty     (q_empty),
    .head      (q_head)
  );

  // Engine next-state: start a queued burst, or issue one beat per free output slot.
  always_comb begin
    state_next      = state_reg;
    beats_left_next = beats_left_reg;
    cur_id_next     = cur_id_reg;
    q_pop           = 1'b0;
    err_entry       = 1'b0;
    issue           = 1'b0;
    out_fifo_pop    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!q_empty) begin
          q_pop           = 1'b1;
          cur_id_next     = head_id;
          beats_left_next = head_len;
          err_entry       = burst_illegal(head_burst, head_size, MAX_SIZE);
          state_next      = err_entry ? ERR : STREAM;
        end
      end
      STREAM: begin
        issue        = !out_fifo_empty && slot_free;
        out_fifo_pop = issue;
      end
      ERR: begin
        issue = slot_free;
      end
      default: state_next = IDLE;
    endcase
    if (issue) begin
      beats_left_next = beats_left_reg - 8'd1;
      if (beats_left_reg == 8'd0) state_next = IDLE;
    end
  end

  // Engine state, burst bookkeeping and error counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      beats_left_reg   <= 8'd0;
      cur_id_reg       <= '0;
      slverr_count_reg <= 16'd0;
    end else begin
      state_reg      <= state_next;
      beats_left_reg <= beats_left_next;
      cur_id_reg     <= cur_id_next;
      if (err_entry && (slverr_count_reg != 16'hFFFF)) begin
        slverr_count_reg <= slverr_count_reg + 16'd1;
      end
    end
  end

  // R output register: loads on issue, otherwise holds until the beat is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid_reg <= 1'b0;
      rlast_reg  <= 1'b0;
      rid_reg    <= '0;
      rdata_reg  <= '0;
      rresp_reg  <= RESP_OKAY;
    end else if (issue) begin
      rvalid_reg <= 1'b1;
      rlast_reg  <= (beats_left_reg == 8'd0);
      rid_reg    <= cur_id_reg;
      if (state_reg == ERR) begin
        rdata_reg <= '0;
        rresp_reg <= RESP_SLVERR;
      end else begin
        rdata_reg <= out_fifo_data;
        rresp_reg <= RESP_OKAY;
      end
    end else if (axs_s0_rready) begin
      rvalid_reg <= 1'b0;
    end
  end

  assign axs_s0_rvalid = rvalid_reg;
  assign axs_s0_rlast  = rlast_reg;
  assign axs_s0_rid    = rid_reg;
  assign axs_s0_rdata  = rdata_reg;
  assign axs_s0_rresp  = rresp_reg;
  assign slverr_count  = slverr_count_reg;
  assign busy          = !q_empty || (state_reg != IDLE) || rvalid_reg;

endmodule
